// File: rtl/vliw_alu_cluster.sv
// N-slot VLIW execute cluster: decodes one wide word per cycle and runs NUM_SLOTS ALU ops in parallel.
// There are two stages. The EX registers drive the outputs, and WB writes the register file on the following edge.
module vliw_alu_cluster #(
    parameter int DATA_W     = 8,
    parameter int NUM_SLOTS  = 2,
    parameter int REG_ADDR_W = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  issue_valid,
    input  logic [NUM_SLOTS*(4+3*REG_ADDR_W)-1:0] instr,
    input  logic [NUM_SLOTS*DATA_W-1:0]           ext_operand,
    output logic [NUM_SLOTS*DATA_W-1:0]           result,
    output logic                                  result_valid,
    output logic [NUM_SLOTS-1:0]                  result_we,
    output logic [NUM_SLOTS-1:0]                  carry,
    output logic                                  wr_conflict,
    output logic                                  illegal_op,
    input  logic [REG_ADDR_W-1:0]                 dbg_addr,
    output logic [DATA_W-1:0]                     dbg_data
);

    localparam int SLOT_W = 4 + 3 * REG_ADDR_W;
    localparam int DEPTH  = 1 << REG_ADDR_W;

    // Issue is valid-only with no backpressure. A word with issue_valid=1 is
    // always accepted, and its results appear exactly one cycle later with result_valid=1.
    logic [DEPTH*DATA_W-1:0]          rf_q;
    logic [NUM_SLOTS*DATA_W-1:0]      res_q, res_d;
    logic [NUM_SLOTS*REG_ADDR_W-1:0]  rd_q, rd_d;
    logic [NUM_SLOTS-1:0]             we_q, we_d;
    logic [NUM_SLOTS-1:0]             carry_q, carry_d;
    logic                             valid_q;
    logic                             illegal_q, illegal_d;
    logic                             conflict;

    always_comb begin
        logic [3:0]            op;
        logic [REG_ADDR_W-1:0] rd, ra, rb;
        logic [DATA_W-1:0]     a, b, y;
        logic [DATA_W:0]       wide;
        logic                  w, c;
        res_d     = '0;
        rd_d      = '0;
        we_d      = '0;
        carry_d   = '0;
        illegal_d = 1'b0;
        op = '0; rd = '0; ra = '0; rb = '0;
        a = '0; b = '0; y = '0; wide = '0; w = 1'b0; c = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            {op, rd, ra, rb} = instr[s*SLOT_W +: SLOT_W];
            a = rf_q[int'(ra)*DATA_W +: DATA_W];
            b = rf_q[int'(rb)*DATA_W +: DATA_W];
            // Bypass from EX. The ascending scan lets the highest matching slot win.
            for (int t = 0; t < NUM_SLOTS; t++) begin
                if (we_q[t] && rd_q[t*REG_ADDR_W +: REG_ADDR_W] == ra)
                    a = res_q[t*DATA_W +: DATA_W];
                if (we_q[t] && rd_q[t*REG_ADDR_W +: REG_ADDR_W] == rb)
                    b = res_q[t*DATA_W +: DATA_W];
            end
            y    = '0;
            w    = 1'b1;
            c    = 1'b0;
            wide = '0;
            case (op)
                4'h0: begin
                    wide = {1'b0, a} + {1'b0, b};
                    y    = wide[DATA_W-1:0];
                    c    = wide[DATA_W];
                end
                4'h1: begin
                    wide = {1'b0, a} - {1'b0, b};
                    y    = wide[DATA_W-1:0];
                    c    = wide[DATA_W];
                end
                4'h2: y = a & b;
                4'h3: y = a | b;
                4'h4: y = a ^ b;
                4'h5: y = ~a;
                4'h6: y = ext_operand[s*DATA_W +: DATA_W];
                4'h7: y = a;
                4'h8: y = a << 1;
                4'h9: y = a >> 1;
                4'hF: w = 1'b0;
                default: begin
                    w         = 1'b0;
                    illegal_d = 1'b1;
                end
            endcase
            res_d[s*DATA_W +: DATA_W]         = y;
            rd_d[s*REG_ADDR_W +: REG_ADDR_W]  = rd;
            we_d[s]                           = w;
            carry_d[s]                        = c;
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = i + 1; j < NUM_SLOTS; j++) begin
                if (we_q[i] && we_q[j] &&
                    rd_q[i*REG_ADDR_W +: REG_ADDR_W] == rd_q[j*REG_ADDR_W +: REG_ADDR_W])
                    conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q      <= '0;
            res_q     <= '0;
            rd_q      <= '0;
            we_q      <= '0;
            carry_q   <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            // Writeback. A later slot's write to the same rd overrides an earlier one.
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (we_q[s])
                    rf_q[int'(rd_q[s*REG_ADDR_W +: REG_ADDR_W])*DATA_W +: DATA_W]
                        <= res_q[s*DATA_W +: DATA_W];
            end
            valid_q <= issue_valid;
            if (issue_valid) begin
                res_q   <= res_d;
                rd_q    <= rd_d;
                we_q    <= we_d;
                carry_q <= carry_d;
                if (illegal_d)
                    illegal_q <= 1'b1;
            end else begin
                we_q    <= '0;
                carry_q <= '0;
            end
        end
    end

    assign result       = res_q;
    assign result_valid = valid_q;
    assign result_we    = we_q;
    assign carry        = carry_q;
    assign wr_conflict  = conflict;
    assign illegal_op   = illegal_q;
    assign dbg_data     = rf_q[int'(dbg_addr)*DATA_W +: DATA_W];

endmodule

// File: tb/tb_vliw_alu_cluster.sv
// Directed test of vliw_alu_cluster at its default parameters (2 slots, 8-bit data, 16 registers).
module tb_vliw_alu_cluster;

    localparam int DATA_W     = 8;
    localparam int NUM_SLOTS  = 2;
    localparam int REG_ADDR_W = 4;
    localparam int SLOT_W     = 4 + 3 * REG_ADDR_W;
    localparam logic [15:0] NOP = 16'hF000;

    logic                          clk;
    logic                          rst;
    logic                          issue_valid;
    logic [NUM_SLOTS*SLOT_W-1:0]   instr;
    logic [NUM_SLOTS*DATA_W-1:0]   ext_operand;
    logic [NUM_SLOTS*DATA_W-1:0]   result;
    logic                          result_valid;
    logic [NUM_SLOTS-1:0]          result_we;
    logic [NUM_SLOTS-1:0]          carry;
    logic                          wr_conflict;
    logic                          illegal_op;
    logic [REG_ADDR_W-1:0]         dbg_addr;
    logic [DATA_W-1:0]             dbg_data;

    int total = 0;
    int bad   = 0;

    vliw_alu_cluster #(
        .DATA_W(DATA_W), .NUM_SLOTS(NUM_SLOTS), .REG_ADDR_W(REG_ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .instr(instr),
        .ext_operand(ext_operand), .result(result), .result_valid(result_valid),
        .result_we(result_we), .carry(carry), .wr_conflict(wr_conflict),
        .illegal_op(illegal_op), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] slot(input logic [3:0] op, input logic [3:0] rd,
                                         input logic [3:0] ra, input logic [3:0] rb);
        return {op, rd, ra, rb};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] s0, input logic [15:0] s1,
                         input logic [7:0] e0, input logic [7:0] e1);
        issue_valid = 1'b1;
        instr       = {s1, s0};
        ext_operand = {e1, e0};
        tick();
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        instr       = {NOP, NOP};
        ext_operand = '0;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [3:0] r, input logic [7:0] exp);
        dbg_addr = r;
        #1;
        chk($sformatf("dbg_r%0d", r), {24'h0, dbg_data}, {24'h0, exp});
    endtask

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        instr       = {NOP, NOP};
        ext_operand = '0;
        dbg_addr    = '0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_result", {16'h0, result}, 32'h0);
        chk("rst_valid", {31'h0, result_valid}, 32'h0);
        chk("rst_we", {30'h0, result_we}, 32'h0);
        chk("rst_carry", {30'h0, carry}, 32'h0);
        chk("rst_conflict", {31'h0, wr_conflict}, 32'h0);
        chk("rst_illegal", {31'h0, illegal_op}, 32'h0);
        for (int r = 0; r < 16; r++) chk_reg(4'(r), 8'h00);

        // bypass: r1/r2 written by MOVX and consumed by the next word
        issue(slot(4'h6, 4'd1, 4'd0, 4'd0), slot(4'h6, 4'd2, 4'd0, 4'd0), 8'h0F, 8'hF0);
        chk("movx_result", {16'h0, result}, 32'hF00F);
        chk("movx_valid", {31'h0, result_valid}, 32'h1);
        chk("movx_we", {30'h0, result_we}, 32'h3);
        chk("movx_conflict", {31'h0, wr_conflict}, 32'h0);
        issue(slot(4'h0, 4'd3, 4'd1, 4'd2), NOP, 8'h00, 8'h00);
        chk("byp_add", {24'h0, result[7:0]}, 32'hFF);
        chk("byp_carry", {30'h0, carry}, 32'h0);
        chk("byp_we", {30'h0, result_we}, 32'h1);
        idle();
        chk("idle_valid", {31'h0, result_valid}, 32'h0);
        chk("idle_we", {30'h0, result_we}, 32'h0);
        chk("idle_hold", {24'h0, result[7:0]}, 32'hFF);
        chk_reg(4'd1, 8'h0F);
        chk_reg(4'd2, 8'hF0);
        chk_reg(4'd3, 8'hFF);

        // carry and borrow
        issue(slot(4'h6, 4'd1, 4'd0, 4'd0), slot(4'h6, 4'd2, 4'd0, 4'd0), 8'hFF, 8'h01);
        idle();
        issue(slot(4'h0, 4'd4, 4'd1, 4'd2), slot(4'h1, 4'd5, 4'd2, 4'd1), 8'h00, 8'h00);
        chk("addsub_result", {16'h0, result}, 32'h0200);
        chk("addsub_carry", {30'h0, carry}, 32'h3);

        // logic, shift and pass ops with r1=FF, r2=01
        issue(slot(4'h2, 4'd8, 4'd1, 4'd2), slot(4'h3, 4'd9, 4'd1, 4'd2), 8'h00, 8'h00);
        chk("and_or", {16'h0, result}, 32'hFF01);
        chk("and_or_carry", {30'h0, carry}, 32'h0);
        issue(slot(4'h4, 4'd8, 4'd1, 4'd2), slot(4'h5, 4'd9, 4'd2, 4'd0), 8'h00, 8'h00);
        chk("xor_not", {16'h0, result}, 32'hFEFE);
        issue(slot(4'h8, 4'd10, 4'd2, 4'd0), slot(4'h9, 4'd11, 4'd1, 4'd0), 8'h00, 8'h00);
        chk("shl_shr", {16'h0, result}, 32'h7F02);
        issue(slot(4'h7, 4'd12, 4'd1, 4'd0), slot(4'h0, 4'd13, 4'd1, 4'd1), 8'h00, 8'h00);
        chk("pass_add", {16'h0, result}, 32'hFEFF);
        chk("pass_add_carry", {30'h0, carry}, 32'h2);
        idle();
        chk_reg(4'd4, 8'h00);
        chk_reg(4'd5, 8'h02);
        chk_reg(4'd11, 8'h7F);

        // write conflict, then bypass of the conflicting rd
        issue(slot(4'h6, 4'd5, 4'd0, 4'd0), slot(4'h6, 4'd5, 4'd0, 4'd0), 8'h11, 8'h22);
        chk("conf_flag", {31'h0, wr_conflict}, 32'h1);
        chk("conf_result", {16'h0, result}, 32'h2211);
        issue(slot(4'h7, 4'd14, 4'd5, 4'd0), NOP, 8'h00, 8'h00);
        chk("conf_flag_drop", {31'h0, wr_conflict}, 32'h0);
        chk("conf_bypass", {24'h0, result[7:0]}, 32'h22);
        idle();
        chk_reg(4'd5, 8'h22);
        chk_reg(4'd14, 8'h22);

        // illegal opcode
        issue(slot(4'hB, 4'd6, 4'd1, 4'd1), NOP, 8'h00, 8'h00);
        chk("ill_we", {30'h0, result_we}, 32'h0);
        chk("ill_valid", {31'h0, result_valid}, 32'h1);
        chk("ill_flag", {31'h0, illegal_op}, 32'h1);
        idle();
        chk_reg(4'd6, 8'h00);
        issue(slot(4'h7, 4'd7, 4'd1, 4'd0), NOP, 8'h00, 8'h00);
        idle();
        chk("ill_sticky", {31'h0, illegal_op}, 32'h1);
        chk_reg(4'd7, 8'hFF);

        // reset while a write is pending in EX
        issue(slot(4'h6, 4'd7, 4'd0, 4'd0), NOP, 8'h5A, 8'h00);
        rst         = 1'b1;
        issue_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {31'h0, result_valid}, 32'h0);
        chk("mid_rst_result", {16'h0, result}, 32'h0);
        chk("mid_rst_illegal", {31'h0, illegal_op}, 32'h0);
        chk_reg(4'd7, 8'h00);
        idle();
        chk_reg(4'd7, 8'h00);
        chk_reg(4'd3, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
